// File: rtl/multi_ctl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes,
// ALU/mux select codes and the packed control word driven to the datapath.
package multi_ctl_pkg;

  typedef enum logic [3:0] {
    ST_IF   = 4'd0,
    ST_ID   = 4'd1,
    ST_MADR = 4'd2,
    ST_MRD  = 4'd3,
    ST_MWB  = 4'd4,
    ST_MWR  = 4'd5,
    ST_REX  = 4'd6,
    ST_RWB  = 4'd7,
    ST_BEQ  = 4'd8,
    ST_JMP  = 4'd9,
    ST_IEX  = 4'd10,
    ST_IWB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       instr_done;
  } ctl_t;

endpackage

// File: rtl/multi_ctl_dec.sv
// Pure combinational decode of the FSM state into the datapath control word.
module multi_ctl_dec
  import multi_ctl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_mem_ready,
  output ctl_t       o_ctl
);

  always_comb begin
    o_ctl = '0;
    case (i_state)
      ST_IF: begin
        o_ctl.mem_read  = 1'b1;
        o_ctl.alu_src_b = SRCB_FOUR;
        o_ctl.alu_op    = ALU_ADD;
        o_ctl.pc_source = PCS_ALU;
        // Fetch completes only when memory returns the word.
        o_ctl.ir_write  = i_mem_ready;
        o_ctl.pc_write  = i_mem_ready;
      end
      ST_ID: begin
        o_ctl.alu_src_b = SRCB_IMMSH;
        o_ctl.alu_op    = ALU_ADD;
      end
      ST_MADR, ST_IEX: begin
        o_ctl.alu_src_a = 1'b1;
        o_ctl.alu_src_b = SRCB_IMM;
        o_ctl.alu_op    = ALU_ADD;
      end
      ST_MRD: begin
        o_ctl.mem_read = 1'b1;
        o_ctl.iord     = 1'b1;
      end
      ST_MWR: begin
        o_ctl.mem_write  = 1'b1;
        o_ctl.iord       = 1'b1;
        o_ctl.instr_done = i_mem_ready;
      end
      ST_MWB: begin
        o_ctl.reg_write  = 1'b1;
        o_ctl.mem_to_reg = 1'b1;
        o_ctl.instr_done = 1'b1;
      end
      ST_REX: begin
        o_ctl.alu_src_a = 1'b1;
        o_ctl.alu_src_b = SRCB_B;
        o_ctl.alu_op    = ALU_FUNCT;
      end
      ST_RWB: begin
        o_ctl.reg_write  = 1'b1;
        o_ctl.reg_dst    = 1'b1;
        o_ctl.instr_done = 1'b1;
      end
      ST_IWB: begin
        o_ctl.reg_write  = 1'b1;
        o_ctl.instr_done = 1'b1;
      end
      ST_BEQ: begin
        o_ctl.alu_src_a     = 1'b1;
        o_ctl.alu_src_b     = SRCB_B;
        o_ctl.alu_op        = ALU_SUB;
        o_ctl.pc_write_cond = 1'b1;
        o_ctl.pc_source     = PCS_ALUOUT;
        o_ctl.instr_done    = 1'b1;
      end
      ST_JMP: begin
        o_ctl.pc_write   = 1'b1;
        o_ctl.pc_source  = PCS_JUMP;
        o_ctl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_ctl.sv
// Multi-cycle MIPS control FSM with memory-ready stalls, illegal-opcode
// detection and a memory-wait timeout.
module multi_ctl
  import multi_ctl_pkg::*;
#(
  parameter int unsigned TMO_CYC = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OP,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic [1:0] PCSource,
  output logic [1:0] ALUop,
  output logic       ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TMO_CYC == 0) ? 0 : TMO_CYC - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_illegal;
  logic             r_mem_err;
  logic             w_illegal;
  logic             w_wait_st;
  logic             w_timeout;
  ctl_t             w_ctl;

  assign w_wait_st = (r_state == ST_IF) || (r_state == ST_MRD) || (r_state == ST_MWR);
  assign w_timeout = (TMO_CYC != 0) && w_wait_st && !mem_ready && (r_cnt == TMO_LAST);

  always_comb begin
    w_next    = ST_IF;
    w_illegal = 1'b0;
    case (r_state)
      ST_IF:   w_next = mem_ready ? ST_ID : ST_IF;
      ST_ID: begin
        case (OP)
          OP_RTYPE:     w_next = ST_REX;
          OP_LW, OP_SW: w_next = ST_MADR;
          OP_BEQ:       w_next = ST_BEQ;
          OP_J:         w_next = ST_JMP;
          OP_ADDI:      w_next = ST_IEX;
          default:      w_illegal = 1'b1;
        endcase
      end
      ST_MADR: begin
        if (OP == OP_LW)      w_next = ST_MRD;
        else if (OP == OP_SW) w_next = ST_MWR;
      end
      ST_MRD:  w_next = mem_ready ? ST_MWB : ST_MRD;
      ST_MWR:  w_next = mem_ready ? ST_IF : ST_MWR;
      ST_REX:  w_next = ST_RWB;
      ST_IEX:  w_next = ST_IWB;
      default: w_next = ST_IF;
    endcase
    if (w_timeout) w_next = ST_IF;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IF;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= w_illegal;
      r_mem_err <= w_timeout;
      // A timeout in IF keeps the state, so restart the wait window explicitly.
      if ((w_next != r_state) || w_timeout)
        r_cnt <= '0;
      else if (w_wait_st && !mem_ready && (r_cnt != '1))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  multi_ctl_dec u_dec (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .o_ctl       (w_ctl)
  );

  assign PCWrite     = w_ctl.pc_write;
  assign PCWriteCond = w_ctl.pc_write_cond;
  assign IorD        = w_ctl.iord;
  assign MemRead     = w_ctl.mem_read;
  assign MemWrite    = w_ctl.mem_write;
  assign IRWrite     = w_ctl.ir_write;
  assign MemtoReg    = w_ctl.mem_to_reg;
  assign PCSource    = w_ctl.pc_source;
  assign ALUop       = w_ctl.alu_op;
  assign ALUsrcA     = w_ctl.alu_src_a;
  assign ALUsrcB     = w_ctl.alu_src_b;
  assign RegWrite    = w_ctl.reg_write;
  assign RegDst      = w_ctl.reg_dst;
  assign instr_done  = w_ctl.instr_done;
  assign illegal_op  = r_illegal;
  assign mem_err     = r_mem_err;
  assign state       = r_state;

endmodule

// File: tb/tb_multi_ctl.sv
// Directed bench for multi_ctl: instruction sequences, stalls, illegal opcode,
// timeout and mid-instruction reset, with hand-computed expectations.
module tb_multi_ctl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] OP;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic [1:0] PCSource, ALUop, ALUsrcB;
  logic       ALUsrcA, RegWrite, RegDst, instr_done, illegal_op, mem_err;
  logic [3:0] state;

  int n_chk  = 0;
  int n_pass = 0;
  int n_done;

  always #5 clk = ~clk;

  multi_ctl #(.TMO_CYC(4), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .OP          (OP),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .PCSource    (PCSource),
    .ALUop       (ALUop),
    .ALUsrcA     (ALUsrcA),
    .ALUsrcB     (ALUsrcB),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .mem_err     (mem_err),
    .state       (state)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_st(input string tag, input int exp_st);
    step();
    chk(tag, 32'(state), exp_st);
  endtask

  initial begin
    rst_n = 1'b0; OP = 6'b100011; mem_ready = 1'b1;
    step(); step();
    chk("rst_state", 32'(state), 0);
    chk("rst_illegal", 32'(illegal_op), 0);
    chk("rst_memerr", 32'(mem_err), 0);
    chk("rst_memread", 32'(MemRead), 1);
    rst_n = 1'b1;
    #1;
    chk("if_irwrite", 32'(IRWrite), 1);
    chk("if_srcb", 32'(ALUsrcB), 1);

    // lw, zero wait: 0,1,2,3,4,0
    n_done = 0;
    begin
      int exp_st[5] = '{1, 2, 3, 4, 0};
      for (int i = 0; i < 5; i++) begin
        step_st("lw_state", exp_st[i]);
        chk("lw_regwrite", 32'(RegWrite), (exp_st[i] == 4) ? 1 : 0);
        chk("lw_memtoreg", 32'(MemtoReg), (exp_st[i] == 4) ? 1 : 0);
        if (instr_done) n_done++;
      end
    end
    chk("lw_done_cnt", n_done, 1);

    // sw with 3 stalled cycles in MWR
    OP = 6'b101011;
    step_st("sw_id", 1);
    step_st("sw_madr", 2);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_st("sw_mwr_wait", 5);
      chk("sw_memwrite", 32'(MemWrite), 1);
      chk("sw_done_wait", 32'(instr_done), 0);
    end
    mem_ready = 1'b1;
    #1;
    chk("sw_done_ready", 32'(instr_done), 1);
    step_st("sw_exit", 0);
    chk("sw_no_memerr", 32'(mem_err), 0);

    // R-type, beq, j back to back
    OP = 6'b000000;
    step_st("r_id", 1);
    step_st("r_rex", 6);
    chk("r_aluop", 32'(ALUop), 2);
    step_st("r_rwb", 7);
    chk("r_regdst", 32'(RegDst), 1);
    chk("r_done", 32'(instr_done), 1);
    step_st("r_exit", 0);
    OP = 6'b000100;
    step_st("beq_id", 1);
    step_st("beq_ex", 8);
    chk("beq_pwc", 32'(PCWriteCond), 1);
    chk("beq_aluop", 32'(ALUop), 1);
    chk("beq_pcsrc", 32'(PCSource), 1);
    step_st("beq_exit", 0);
    OP = 6'b000010;
    step_st("j_id", 1);
    step_st("j_ex", 9);
    chk("j_pcwrite", 32'(PCWrite), 1);
    chk("j_pcsrc", 32'(PCSource), 2);
    step_st("j_exit", 0);

    // illegal opcode
    OP = 6'b111111;
    chk("ill_if_pre", 32'(illegal_op), 0);
    step_st("ill_id", 1);
    chk("ill_id_wr", 32'(RegWrite | MemWrite), 0);
    step_st("ill_back_if", 0);
    chk("ill_pulse", 32'(illegal_op), 1);
    chk("ill_if_wr", 32'(RegWrite | MemWrite), 0);
    mem_ready = 1'b0;
    step_st("ill_hold_if", 0);
    chk("ill_pulse_end", 32'(illegal_op), 0);
    mem_ready = 1'b1;

    // timeout in MRD
    OP = 6'b100011;
    step_st("tmo_id", 1);
    step_st("tmo_madr", 2);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step_st("tmo_mrd", 3);
    step_st("tmo_to_if", 0);
    chk("tmo_memerr", 32'(mem_err), 1);
    mem_ready = 1'b1;
    step_st("tmo_next_id", 1);
    chk("tmo_memerr_end", 32'(mem_err), 0);

    // ready on the last allowed cycle wins over the timeout
    step_st("rdy_madr", 2);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step_st("rdy_mrd", 3);
    step_st("rdy_mrd4", 3);
    mem_ready = 1'b1;
    step_st("rdy_mwb", 4);
    chk("rdy_no_memerr", 32'(mem_err), 0);
    step_st("rdy_exit", 0);

    // reset while in MRD
    step_st("mr_id", 1);
    step_st("mr_madr", 2);
    mem_ready = 1'b0;
    step_st("mr_mrd", 3);
    rst_n = 1'b0;
    step_st("mr_rst_state", 0);
    chk("mr_memread", 32'(MemRead), 1);
    chk("mr_iord", 32'(IorD), 0);
    chk("mr_srcb", 32'(ALUsrcB), 1);
    chk("mr_irwrite", 32'(IRWrite), 0);
    chk("mr_wr", 32'(RegWrite | MemWrite), 0);
    chk("mr_flags", 32'(illegal_op | mem_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
